// File: rtl/otf_feed_arb.sv
// Two-requester round-robin arbiter that feeds 16-bit jobs MSB-first as 2-bit digits
// into an on-the-fly datapath and captures its result after a fixed latency.
module otf_feed_arb #(
    parameter int DIGITS = 8,
    parameter int LAT    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    output logic        ack0,
    output logic        ack1,
    output logic        otf_rst,
    output logic        otf_valid,
    output logic [1:0]  otf_i,
    input  logic [15:0] otf_o,
    output logic        res_valid,
    output logic        res_id,
    output logic [15:0] result,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_FEED,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [2:0] LAST_DIG  = 3'(DIGITS - 1);
    localparam logic [2:0] LAST_WAIT = 3'(LAT - 1);

    state_t      state_q, state_d;
    logic [15:0] word_q, word_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        gid_q, gid_d;
    logic        last_q, last_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic        valid_q, valid_d;
    logic [1:0]  dig_q, dig_d;
    logic        resv_q, resv_d;
    logic        res_id_q, res_id_d;
    logic [15:0] result_q, result_d;
    logic        busy_q, busy_d;

    logic any_req;
    logic pick1;
    logic accept;

    assign any_req = req0 | req1;
    // last_q == 1 means req1 was served last, so a tie goes to req0
    assign pick1   = req1 & (~req0 | ~last_q);

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        cnt_d    = cnt_q;
        gid_d    = gid_q;
        last_d   = last_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        valid_d  = 1'b0;
        dig_d    = 2'b00;
        resv_d   = 1'b0;
        res_id_d = res_id_q;
        result_d = result_q;
        accept   = 1'b0;

        unique case (state_q)
            S_IDLE: accept = any_req;
            S_CLR: begin
                state_d = S_FEED;
                cnt_d   = '0;
                valid_d = 1'b1;
                dig_d   = word_q[15:14];
                word_d  = {word_q[13:0], 2'b00};
            end
            S_FEED: begin
                if (cnt_q == LAST_DIG) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 3'd1;
                    valid_d = 1'b1;
                    dig_d   = word_q[15:14];
                    word_d  = {word_q[13:0], 2'b00};
                end
            end
            S_WAIT: begin
                if (cnt_q == LAST_WAIT) begin
                    state_d  = S_DONE;
                    resv_d   = 1'b1;
                    result_d = otf_o;
                    res_id_d = gid_q;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_DONE: begin
                // accepting straight out of DONE keeps back-to-back jobs at 11 cycles
                state_d = S_IDLE;
                accept  = any_req;
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            state_d = S_CLR;
            word_d  = pick1 ? data1 : data0;
            gid_d   = pick1;
            last_d  = pick1;
            ack0_d  = ~pick1;
            ack1_d  = pick1;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            word_q   <= '0;
            cnt_q    <= '0;
            gid_q    <= 1'b0;
            last_q   <= 1'b1;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            valid_q  <= 1'b0;
            dig_q    <= '0;
            resv_q   <= 1'b0;
            res_id_q <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            cnt_q    <= cnt_d;
            gid_q    <= gid_d;
            last_q   <= last_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            valid_q  <= valid_d;
            dig_q    <= dig_d;
            resv_q   <= resv_d;
            res_id_q <= res_id_d;
            result_q <= result_d;
            busy_q   <= busy_d;
        end
    end

    assign otf_rst   = reset | (state_q == S_CLR);
    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign otf_valid = valid_q;
    assign otf_i     = dig_q;
    assign res_valid = resv_q;
    assign res_id    = res_id_q;
    assign result    = result_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_otf_feed_arb.sv
// Scoreboard bench for otf_feed_arb: a shift-accumulator stands in for the datapath,
// grants/digits/results are queued on acceptance and compared as the DUT emits them.
module tb_otf_feed_arb;

    logic        clk;
    logic        reset;
    logic        req0, req1;
    logic [15:0] data0, data1;
    logic        ack0, ack1;
    logic        otf_rst, otf_valid;
    logic [1:0]  otf_i;
    logic [15:0] otf_o;
    logic        res_valid, res_id;
    logic [15:0] result;
    logic        busy;

    otf_feed_arb #(.DIGITS(8), .LAT(1)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .data0(data0), .data1(data1),
        .ack0(ack0), .ack1(ack1),
        .otf_rst(otf_rst), .otf_valid(otf_valid), .otf_i(otf_i), .otf_o(otf_o),
        .res_valid(res_valid), .res_id(res_id), .result(result), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // datapath stand-in: shifts digits in MSB-first
    logic [15:0] acc;
    logic        stub = 1'b0;
    always @(posedge clk) begin
        if (otf_rst)        acc <= '0;
        else if (otf_valid) acc <= {acc[13:0], otf_i};
    end
    assign otf_o = stub ? 16'h1234 : acc;

    logic [15:0] jobs0[$];
    logic [15:0] jobs1[$];
    int          exp_gnt[$];
    logic [16:0] exp_res[$];
    logic [1:0]  exp_dig[$];
    int          ack_log[$];

    int          cyc = 0;
    int          ack_cyc = 0;
    int          feedcnt = 0;
    int          rstcnt = 0;
    logic        prev_ack = 1'b0;
    logic        drop0 = 1'b0, drop1 = 1'b0;
    logic        hold1 = 1'b0;
    logic [15:0] w;
    logic [16:0] e;
    logic        gid;

    initial begin
        req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
    end

    always @(negedge clk) begin
        drop0 = 1'b0;
        drop1 = 1'b0;
        if (!reset) begin
            cyc++;
            if (ack0 | ack1) begin
                gid = ack1;
                chk("ack_onehot", {31'd0, ack0 & ack1}, 0);
                chk("ack_pulse", {31'd0, prev_ack}, 0);
                if (exp_gnt.size() > 0) chk("grant", {31'd0, gid}, exp_gnt.pop_front());
                else chk("unexpected_ack", 1, 0);
                w = gid ? data1 : data0;
                exp_res.push_back({gid, stub ? 16'h1234 : w});
                for (int k = 0; k < 8; k++) exp_dig.push_back(w[15-2*k -: 2]);
                ack_cyc = cyc;
                feedcnt = 0;
                rstcnt  = 0;
                ack_log.push_back(cyc);
                if (gid) begin
                    if (jobs1.size() > 0) void'(jobs1.pop_front());
                    drop1 = 1'b1;
                end else begin
                    if (jobs0.size() > 0) void'(jobs0.pop_front());
                    drop0 = 1'b1;
                end
            end
            prev_ack = ack0 | ack1;
            if (otf_rst) rstcnt++;
            if (otf_valid) begin
                feedcnt++;
                if (exp_dig.size() > 0) chk("digit", {30'd0, otf_i}, {30'd0, exp_dig.pop_front()});
                else chk("unexpected_valid", 1, 0);
            end else if (otf_i != 2'b00) begin
                chk("otf_i_when_invalid", {30'd0, otf_i}, 0);
            end
            if (res_valid) begin
                chk("latency", cyc - ack_cyc, 10);
                chk("feed_cycles", feedcnt, 8);
                chk("clr_cycles", rstcnt, 1);
                if (exp_res.size() > 0) begin
                    e = exp_res.pop_front();
                    chk("res_id", {31'd0, res_id}, {31'd0, e[16]});
                    chk("result", {16'd0, result}, {16'd0, e[15:0]});
                end else begin
                    chk("unexpected_res_valid", 1, 0);
                end
            end
        end
        req0 = (jobs0.size() > 0) && !drop0;
        req1 = (jobs1.size() > 0) && !(drop1 && !hold1);
        if (jobs0.size() > 0) data0 = jobs0[0];
        if (jobs1.size() > 0) data1 = jobs1[0];
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ack0"}, {31'd0, ack0}, 0);
        chk({tag, "_ack1"}, {31'd0, ack1}, 0);
        chk({tag, "_otf_rst"}, {31'd0, otf_rst}, 1);
        chk({tag, "_otf_valid"}, {31'd0, otf_valid}, 0);
        chk({tag, "_otf_i"}, {30'd0, otf_i}, 0);
        chk({tag, "_res_valid"}, {31'd0, res_valid}, 0);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        jobs0.delete(); jobs1.delete();
        reset = 1'b1;
        #1;
        check_reset_outputs("rst");
        chk("rst_res_id", {31'd0, res_id}, 0);
        chk("rst_result", {16'd0, result}, 0);
        exp_res.delete(); exp_dig.delete(); exp_gnt.delete(); ack_log.delete();
        @(negedge clk);
        #1;
        reset = 1'b0;
        prev_ack = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int i;
        i = 0;
        while ((busy || req0 || req1 || jobs0.size() > 0 || jobs1.size() > 0 ||
                exp_res.size() > 0) && i < max_cyc) begin
            @(negedge clk);
            #1;
            i++;
        end
        repeat (2) @(negedge clk);
        #1;
        if (i >= max_cyc) chk("timeout", 1, 0);
        chk("grants_left", exp_gnt.size(), 0);
    endtask

    initial begin
        reset = 1'b0;
        #3 reset = 1'b1;
        #3;
        check_reset_outputs("por");
        chk("por_result", {16'd0, result}, 0);
        @(negedge clk);
        #1 reset = 1'b0;

        // single job on requester 0
        exp_gnt.push_back(0);
        jobs0.push_back(16'hB4E1);
        wait_idle(60);

        // result capture from a stubbed datapath, held after the strobe
        stub = 1'b1;
        exp_gnt.push_back(1);
        jobs1.push_back(16'h5A3C);
        wait_idle(60);
        repeat (3) @(negedge clk);
        #1;
        chk("result_hold", {16'd0, result}, 32'h1234);
        chk("res_id_hold", {31'd0, res_id}, 1);
        chk("res_valid_low", {31'd0, res_valid}, 0);
        stub = 1'b0;

        // contention right after reset: req0 first, req1 eleven cycles later
        do_reset();
        exp_gnt.push_back(0);
        exp_gnt.push_back(1);
        jobs0.push_back(16'h0F0F);
        jobs1.push_back(16'hC3A5);
        wait_idle(80);
        if (ack_log.size() == 2) chk("ack_gap", ack_log[1] - ack_log[0], 11);
        else chk("ack_count", ack_log.size(), 2);

        // fairness: req1 held, req0 re-requests after each ack
        do_reset();
        hold1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_gnt.push_back(0);
            exp_gnt.push_back(1);
            jobs0.push_back(16'($urandom));
            jobs1.push_back(16'($urandom));
        end
        wait_idle(200);
        hold1 = 1'b0;

        // reset in the middle of the feed abandons the job
        do_reset();
        exp_gnt.push_back(0);
        jobs0.push_back(16'h9876);
        jobs1.push_back(16'h1357);
        begin
            int i;
            i = 0;
            do begin
                @(negedge clk);
                #2;
                i++;
            end while (!(otf_valid && feedcnt == 4) && i < 40);
            if (i >= 40) chk("midrst_timeout", 1, 0);
        end
        reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        exp_res.delete(); exp_dig.delete();
        exp_gnt.push_back(1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        prev_ack = 1'b0;
        @(negedge clk);
        #1;
        chk("midrst_ack1_first_edge", {31'd0, ack1}, 1);
        wait_idle(60);

        // idle: nothing requested for 20 cycles
        begin
            logic seen;
            seen = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                #1;
                seen = seen | busy | otf_valid | ack0 | ack1 | res_valid;
            end
            chk("idle_quiet", {31'd0, seen}, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/otf_feed_arb.md
OTF_FEED_ARB -- requirements
Module: otf_feed_arb

Interface
REQ-001 The block SHALL have parameter DIGITS, default 8, meaning 2-bit digits per 16-bit job (fixed; 2*DIGITS = 16).
REQ-002 The block SHALL have parameter LAT, default 1, meaning idle cycles between the last digit and result capture (range 1..7).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port req0 / req1, input, 1 bit each: requester job requests.
REQ-006 The block SHALL have port data0 / data1, input, 16 bits each: job words, held stable while the matching req is high.
REQ-007 The block SHALL have port ack0 / ack1, output, 1 bit each: one-cycle acceptance pulses.
REQ-008 The block SHALL have port otf_rst, output, 1 bit: clear to the on_the_fly datapath reset.
REQ-009 The block SHALL have port otf_valid, output, 1 bit: digit valid to the datapath.
REQ-010 The block SHALL have port otf_i, output, 2 bits: digit to the datapath.
REQ-011 The block SHALL have port otf_o, input, 16 bits: datapath result.
REQ-012 The block SHALL have port res_valid, output, 1 bit: one-cycle result strobe.
REQ-013 The block SHALL have port res_id, output, 1 bit: requester that owns the result.
REQ-014 The block SHALL have port result, output, 16 bits: captured otf_o.
REQ-015 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-016 The block SHALL implement states IDLE, CLR, FEED, WAIT and DONE. All outputs except otf_rst SHALL be registered.
REQ-017 In IDLE at a rising edge, if any req is high, the block SHALL accept one requester, latch its data and id, and go to CLR. Otherwise it SHALL stay in IDLE.
REQ-018 Arbitration SHALL be round-robin using a last-served pointer. If only one req is high, that requester wins. If both are high, the requester not last served wins. After reset the pointer SHALL favour req0.
REQ-019 The ack of the accepted requester SHALL be high for exactly the cycle after acceptance. The requester drops req after seeing ack. A req still high in the cycle of its own ack SHALL NOT be accepted again in that cycle.
REQ-020 In CLR (1 cycle), otf_rst SHALL be 1 and otf_valid SHALL be 0.
REQ-021 In FEED (DIGITS cycles), otf_valid SHALL be 1 and otf_i SHALL present the latched word MSB-first: bits [15:14] in feed cycle 1 and bits [1:0] in feed cycle 8. A 3-bit digit counter SHALL run 0..DIGITS-1 with no wrap past the last digit.
REQ-022 In WAIT (LAT cycles), otf_valid SHALL be 0 and otf_i SHALL be 0.
REQ-023 At the edge leaving WAIT, the block SHALL capture result <= otf_o and res_id <= the granted id.
REQ-024 In DONE (1 cycle), res_valid SHALL be 1, after which the block SHALL return to IDLE.
REQ-025 result and res_id SHALL hold their values until the next capture.
REQ-026 Job timing, taking acceptance edge E0: CLR after E0, FEED after E1..E8, WAIT after E9, res_valid after E10, IDLE after E11. The earliest next acceptance SHALL be at E11, giving 11 cycles per job with LAT=1.
REQ-027 Changes on req or data while busy SHALL be ignored. A pending request SHALL be served in the next IDLE according to the pointer.
REQ-028 otf_valid SHALL be 0 and otf_i SHALL be 0 in IDLE, CLR, WAIT and DONE.

Reset
REQ-029 While reset is high, the block SHALL force state=IDLE, pointer favouring req0, ack0=ack1=0, otf_valid=0, otf_i=0, res_valid=0, res_id=0, result=16'h0000 and busy=0, all asynchronously.
REQ-030 otf_rst SHALL equal reset OR (state==CLR), so the datapath is cleared during block reset.
REQ-031 A reset in any state SHALL abandon the job with no ack and no res_valid. After reset deasserts, a still-high req SHALL be accepted at the first rising edge.

Verification
REQ-032 Single job: req0=1, data0=16'hB4E1 -> ack0 one cycle; otf_rst for 1 cycle; otf_valid for 8 cycles with otf_i = 2,3,1,0,3,2,0,1; res_valid at E10+ with res_id=0.
REQ-033 Capture: stub otf_o=16'h1234 during WAIT -> result=16'h1234, held after res_valid drops.
REQ-034 Contention: after reset, req0 and req1 held high together -> req0 served first, req1 next (ack1 at E11+1 cycle); res_id sequence 0,1.
REQ-035 Fairness: req1 held high while req0 re-requests after every ack -> grants alternate 0,1,0,1 with no requester served twice in a row.
REQ-036 Mid-job reset: reset pulsed at feed digit 4 -> otf_valid=0 and otf_rst=1 immediately, busy=0, no res_valid; after release a pending req1 is accepted at the first edge.
REQ-037 Idle: no req for 20 cycles -> busy=0, otf_valid=0, no ack, no res_valid.
